// File: rtl/msrv32_wb_pkg.sv
// Shared encodings for the writeback stage: result-select codes, load sizes,
// FSM state type and the default memory-wait budget.
package msrv32_wb_pkg;

   localparam logic [2:0] WB_ALU  = 3'd0;
   localparam logic [2:0] WB_LOAD = 3'd1;
   localparam logic [2:0] WB_IMM  = 3'd2;
   localparam logic [2:0] WB_PC4  = 3'd3;
   localparam logic [2:0] WB_CSR  = 3'd4;

   localparam logic [1:0] LS_BYTE = 2'd0;
   localparam logic [1:0] LS_HALF = 2'd1;
   localparam logic [1:0] LS_WORD = 2'd2;
   localparam logic [1:0] LS_RSVD = 2'd3;

   localparam int TIMEOUT_DEFAULT = 16;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_WAIT_MEM = 1'b1
   } wb_state_e;

   // Reserved size is rejected alongside genuinely misaligned accesses.
   function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] addr);
      return (size == LS_RSVD) ||
             ((size == LS_HALF) && addr[0]) ||
             ((size == LS_WORD) && (addr != 2'b00));
   endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Combinational load-data alignment: picks the addressed byte/half out of the
// memory word and sign- or zero-extends it to 32 bits.
module msrv32_load_align
   import msrv32_wb_pkg::*;
(
   input  logic [31:0] rdata_in,
   input  logic [1:0]  addr_in,
   input  logic [1:0]  size_in,
   input  logic        unsigned_in,
   output logic [31:0] result_out
);

   logic [31:0] shifted;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   always_comb begin
      shifted    = rdata_in >> {addr_in, 3'b000};
      byte_val   = shifted[7:0];
      half_val   = addr_in[1] ? rdata_in[31:16] : rdata_in[15:0];
      result_out = rdata_in;
      case (size_in)
         LS_BYTE: result_out = {{24{byte_val[7] & ~unsigned_in}}, byte_val};
         LS_HALF: result_out = {{16{half_val[15] & ~unsigned_in}}, half_val};
         default: result_out = rdata_in;
      endcase
   end

endmodule

// File: rtl/msrv32_wb_stage.sv
// Writeback stage: selects the retiring result, waits on data memory for loads
// and drives a registered single-cycle register-file write pulse.
module msrv32_wb_stage
   import msrv32_wb_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        valid_in,
   output logic        ready_out,
   input  logic [4:0]  rd_addr_in,
   input  logic        rf_wr_en_in,
   input  logic [2:0]  wb_sel_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] imm_in,
   input  logic [31:0] pc_plus_4_in,
   input  logic [31:0] csr_data_in,
   input  logic [1:0]  load_size_in,
   input  logic        load_unsigned_in,
   input  logic [31:0] dmem_rdata_in,
   input  logic        dmem_ack_in,
   output logic [4:0]  rd_addr_out,
   output logic        wr_en_out,
   output logic [31:0] rd_out,
   output logic        load_err_out
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   wb_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic        wr_en_q, wr_en_d;
   logic [31:0] rd_q, rd_d;
   logic        load_err_q, load_err_d;
   logic [4:0]  ld_rd_q, ld_rd_d;
   logic        ld_we_q, ld_we_d;
   logic [1:0]  ld_size_q, ld_size_d;
   logic        ld_uns_q, ld_uns_d;
   logic [1:0]  ld_addr_q, ld_addr_d;

   logic [31:0] nl_result;
   logic [31:0] ld_result;

   msrv32_load_align u_align (
      .rdata_in    (dmem_rdata_in),
      .addr_in     (ld_addr_q),
      .size_in     (ld_size_q),
      .unsigned_in (ld_uns_q),
      .result_out  (ld_result)
   );

   always_comb begin
      nl_result = alu_result_in;
      case (wb_sel_in)
         WB_IMM:  nl_result = imm_in;
         WB_PC4:  nl_result = pc_plus_4_in;
         WB_CSR:  nl_result = csr_data_in;
         default: nl_result = alu_result_in;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_addr_d  = rd_addr_q;
      rd_d       = rd_q;
      wr_en_d    = 1'b0;
      load_err_d = 1'b0;
      ld_rd_d    = ld_rd_q;
      ld_we_d    = ld_we_q;
      ld_size_d  = ld_size_q;
      ld_uns_d   = ld_uns_q;
      ld_addr_d  = ld_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (valid_in) begin
               if (wb_sel_in == WB_LOAD) begin
                  if (load_misaligned(load_size_in, alu_result_in[1:0])) begin
                     load_err_d = 1'b1;
                  end else begin
                     ld_rd_d   = rd_addr_in;
                     ld_we_d   = rf_wr_en_in;
                     ld_size_d = load_size_in;
                     ld_uns_d  = load_unsigned_in;
                     ld_addr_d = alu_result_in[1:0];
                     cnt_d     = '0;
                     state_d   = ST_WAIT_MEM;
                  end
               end else begin
                  rd_addr_d = rd_addr_in;
                  rd_d      = nl_result;
                  wr_en_d   = rf_wr_en_in && (rd_addr_in != 5'd0);
               end
            end
         end
         ST_WAIT_MEM: begin
            // An ack on the last allowed cycle still completes the load.
            if (dmem_ack_in) begin
               rd_addr_d = ld_rd_q;
               rd_d      = ld_result;
               wr_en_d   = ld_we_q && (ld_rd_q != 5'd0);
               state_d   = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               load_err_d = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rd_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         rd_q       <= '0;
         load_err_q <= 1'b0;
         ld_rd_q    <= '0;
         ld_we_q    <= 1'b0;
         ld_size_q  <= '0;
         ld_uns_q   <= 1'b0;
         ld_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_addr_q  <= rd_addr_d;
         wr_en_q    <= wr_en_d;
         rd_q       <= rd_d;
         load_err_q <= load_err_d;
         ld_rd_q    <= ld_rd_d;
         ld_we_q    <= ld_we_d;
         ld_size_q  <= ld_size_d;
         ld_uns_q   <= ld_uns_d;
         ld_addr_q  <= ld_addr_d;
      end
   end

   assign ready_out    = (state_q == ST_IDLE);
   assign rd_addr_out  = rd_addr_q;
   assign wr_en_out    = wr_en_q;
   assign rd_out       = rd_q;
   assign load_err_out = load_err_q;

endmodule
